// File: rtl/mul_tile_pipe_pkg.sv
// Shared constants and helpers for the tiled MMM multiplier variants.
package mul_tile_pipe_pkg;

    localparam int unsigned IDW_MIN = 8;
    localparam int unsigned IDW_MAX = 512;
    localparam int unsigned TAW_MIN = 1;
    localparam int unsigned TAW_MAX = 27;
    localparam int unsigned TBW_MIN = 1;
    localparam int unsigned TBW_MAX = 18;
    localparam int unsigned LAT_MIN = 2;
    localparam int unsigned LAT_MAX = 3;

    // Number of d-bit tiles needed to cover n bits.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    function automatic bit lat_legal(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mul_tile_pipe_if.sv
// Operand/result handshake bundle for the tiled multiplier.
interface mul_tile_pipe_if #(
    parameter int unsigned IDW = 90,
    parameter int unsigned ODW = 2 * IDW + 1,
    parameter int unsigned TGW = 4
);
    // Operand channel
    logic           in_valid;
    logic           in_ready;
    logic [IDW-1:0] a;
    logic [IDW-1:0] b;
    logic           carry;
    logic [TGW-1:0] in_tag;
    // Result channel
    logic           out_valid;
    logic           out_ready;
    logic [ODW-1:0] res;
    logic [TGW-1:0] out_tag;

    modport master (
        output in_valid, a, b, carry, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag
    );

    modport slave (
        input  in_valid, a, b, carry, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag
    );

endinterface

// File: rtl/mul_tile_row.sv
// One a-side tile row: registers NB tile products and forms the shifted row sum,
// registered when the pipe is three deep, combinational when it is two deep.
module mul_tile_row
    import mul_tile_pipe_pkg::*;
#(
    parameter int unsigned TAW = 24,
    parameter int unsigned TBW = 16,
    parameter int unsigned NB  = 6,
    parameter int unsigned LAT = 3,
    localparam int unsigned PW = TAW + TBW,
    localparam int unsigned RW = TAW + NB * TBW + 1
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [TAW-1:0]    i_x,
    input  logic [NB*TBW-1:0] i_y,
    output logic [RW-1:0]     o_row
);

    logic [PW-1:0] r_p [NB];
    logic [RW-1:0] w_row;

    // Stage 1: one DSP-sized product per b-side tile
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int j = 0; j < NB; j++) begin
                r_p[j] <= PW'(i_x) * PW'(i_y[j*TBW +: TBW]);
            end
        end
    end

    // Row sum of the products, each placed at its b-tile offset
    always_comb begin
        w_row = '0;
        for (int j = 0; j < NB; j++) begin
            w_row = w_row + (RW'(r_p[j]) << (j * TBW));
        end
    end

    if (LAT == LAT_MAX) begin : g_row_reg
        logic [RW-1:0] r_row;

        // Stage 2: registered row sum
        always_ff @(posedge i_clk) begin
            if (i_en) begin
                r_row <= w_row;
            end
        end

        assign o_row = r_row;
    end else begin : g_row_comb
        assign o_row = w_row;
    end

endmodule

// File: rtl/mul_tile_pipe.sv
// Pipelined tiled schoolbook multiplier: res = a * b + carry, with valid/ready
// backpressure (global stall) and a sideband tag travelling alongside the data.
module mul_tile_pipe
    import mul_tile_pipe_pkg::*;
#(
    parameter int unsigned IDW = 90,
    parameter int unsigned TAW = 24,
    parameter int unsigned TBW = 16,
    parameter int unsigned ODW = 2 * IDW + 1,
    parameter int unsigned TGW = 4,
    parameter int unsigned LAT = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mul_tile_pipe_if.slave io_bus
);

    localparam int unsigned NA = ceil_div(IDW, TAW);
    localparam int unsigned NB = ceil_div(IDW, TBW);
    localparam int unsigned RW = TAW + NB * TBW + 1;
    localparam int unsigned SW = NA * TAW + NB * TBW + 1;
    // Stages ahead of the output register
    localparam int unsigned ND = LAT - 1;

    if (ODW < 2 * IDW) begin : g_err_odw
        $error("mul_tile_pipe: ODW must be at least 2*IDW");
    end
    if (!lat_legal(LAT)) begin : g_err_lat
        $error("mul_tile_pipe: LAT must be 2 or 3");
    end
    if (IDW < IDW_MIN || IDW > IDW_MAX) begin : g_err_idw
        $error("mul_tile_pipe: IDW out of range");
    end
    if (TAW < TAW_MIN || TAW > TAW_MAX || TBW < TBW_MIN || TBW > TBW_MAX) begin : g_err_tile
        $error("mul_tile_pipe: tile width out of range");
    end

    logic              w_en;
    logic [NA*TAW-1:0] w_a_pad;
    logic [NB*TBW-1:0] w_b_pad;
    logic [RW-1:0]     w_row [NA];
    logic [SW-1:0]     w_sum;

    logic [ND-1:0]     r_vld;
    logic [ND-1:0]     r_cry;
    logic [TGW-1:0]    r_tag [ND];
    logic              r_out_vld;
    logic [ODW-1:0]    r_res;
    logic [TGW-1:0]    r_out_tag;

    // Whole pipe advances together; only a held result blocks it
    assign w_en            = !r_out_vld || io_bus.out_ready;
    assign io_bus.in_ready = w_en;

    assign w_a_pad = (NA * TAW)'(io_bus.a);
    assign w_b_pad = (NB * TBW)'(io_bus.b);

    for (genvar i = 0; i < NA; i++) begin : g_row
        mul_tile_row #(
            .TAW (TAW),
            .TBW (TBW),
            .NB  (NB),
            .LAT (LAT)
        ) u_row (
            .i_clk (i_clk),
            .i_en  (w_en),
            .i_x   (w_a_pad[i*TAW +: TAW]),
            .i_y   (w_b_pad),
            .o_row (w_row[i])
        );
    end

    // Valid/carry/tag pipe matching the data stages
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            r_cry <= '0;
            for (int k = 0; k < ND; k++) begin
                r_tag[k] <= '0;
            end
        end else if (w_en) begin
            r_vld[0] <= io_bus.in_valid;
            r_cry[0] <= io_bus.carry;
            r_tag[0] <= io_bus.in_tag;
            for (int k = 1; k < ND; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_cry[k] <= r_cry[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Column add: rows at their a-tile offsets plus carry, at full width
    always_comb begin
        w_sum = SW'(r_cry[ND-1]);
        for (int i = 0; i < NA; i++) begin
            w_sum = w_sum + (SW'(w_row[i]) << (i * TAW));
        end
    end

    // Output register; truncation to ODW happens only here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_vld <= 1'b0;
            r_res     <= '0;
            r_out_tag <= '0;
        end else if (w_en) begin
            r_out_vld <= r_vld[ND-1];
            r_res     <= ODW'(w_sum);
            r_out_tag <= r_tag[ND-1];
        end
    end

    assign io_bus.out_valid = r_out_vld;
    assign io_bus.res       = r_res;
    assign io_bus.out_tag   = r_out_tag;

endmodule
